// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/flow controller.
// Signal suffixes are from the controller's point of view.
interface pipeline_ctrl_if;
  logic        id_r1_enable_i;
  logic        id_r2_enable_i;
  logic [4:0]  id_r1_addr_i;
  logic [4:0]  id_r2_addr_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_w_addr_i;
  logic        mem_busy_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [4:0]  stall_o;
  logic        flush_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic [31:0] stall_cnt_o;
  logic        timeout_o;

  // Datapath side: drives hazard inputs, consumes control outputs
  modport master (
    output id_r1_enable_i, id_r2_enable_i, id_r1_addr_i, id_r2_addr_i,
    output ex_is_load_i, ex_w_addr_i, mem_busy_i, branch_taken_i, branch_target_i,
    input  stall_o, flush_o, pc_redirect_o, pc_target_o, stall_cnt_o, timeout_o
  );

  // Controller side
  modport slave (
    input  id_r1_enable_i, id_r2_enable_i, id_r1_addr_i, id_r2_addr_i,
    input  ex_is_load_i, ex_w_addr_i, mem_busy_i, branch_taken_i, branch_target_i,
    output stall_o, flush_o, pc_redirect_o, pc_target_o, stall_cnt_o, timeout_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline flow controller: load-use bubbles, memory-wait freeze
// with timeout detection, and branch flush/redirect sequencing.
module pipeline_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        load_use;
  logic        accept_br;
  logic        tmo_hit;
  logic [4:0]  stall_d;
  logic        flush_d;
  logic        redirect_d;
  logic [4:0]  stall_out;

  // Hazard on a register written by an in-flight load (x0 never hazards)
  assign load_use = bus.ex_is_load_i && (bus.ex_w_addr_i != 5'd0) &&
                    ((bus.id_r1_enable_i && (bus.id_r1_addr_i == bus.ex_w_addr_i)) ||
                     (bus.id_r2_enable_i && (bus.id_r2_addr_i == bus.ex_w_addr_i)));

  // Only the first branch counts until its flush has been performed
  assign accept_br = bus.branch_taken_i && !pending_q && (state_q != FLUSH);

  // The 255th MEM_WAIT cycle is the one that sees 254 completed cycles
  assign tmo_hit = (state_q == MEM_WAIT) && (wait_cnt_q == 8'd254);

  // Next-state and control decode; priority is mem_busy > flush > load-use
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pc_target_d = pc_target_q;
    stall_d     = 5'b00000;
    flush_d     = 1'b0;
    redirect_d  = 1'b0;
    if (accept_br) pc_target_d = bus.branch_target_i;
    if (bus.mem_busy_i) begin
      stall_d = 5'b11111;
      state_d = MEM_WAIT;
      // A flush interrupted by memory, or a new branch, is replayed after the wait
      if (accept_br || (state_q == FLUSH)) pending_d = 1'b1;
    end else if (state_q == FLUSH) begin
      flush_d    = 1'b1;
      redirect_d = 1'b1;
      state_d    = RUN;
    end else if (pending_q || accept_br) begin
      // Consumer in ID is on the wrong path, so no load-use bubble is needed
      state_d   = FLUSH;
      pending_d = 1'b0;
    end else begin
      state_d = RUN;
      if (load_use) stall_d = 5'b00011;
    end
  end

  // Outputs are forced quiet while reset is held, even if mem_busy is high
  assign stall_out         = rst_n ? stall_d : 5'b00000;
  assign bus.stall_o       = stall_out;
  assign bus.flush_o       = rst_n && flush_d;
  assign bus.pc_redirect_o = rst_n && redirect_d;
  assign bus.pc_target_o   = pc_target_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.timeout_o     = rst_n && (timeout_q || tmo_hit);

  // Wait counter, sticky timeout and saturating stall counter
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q != MEM_WAIT) && (state_d == MEM_WAIT)) wait_cnt_d = 8'd0;
    else if ((state_q == MEM_WAIT) && (wait_cnt_q != 8'hFF)) wait_cnt_d = wait_cnt_q + 8'd1;
    timeout_d   = timeout_q || tmo_hit;
    stall_cnt_d = stall_cnt_q;
    if (stall_out[0] && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pending_q   <= 1'b0;
      pc_target_q <= 32'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pc_target_q <= pc_target_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_pipeline_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  pipeline_ctrl_if bus_if ();

  pipeline_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_if.id_r1_enable_i  = 1'b0;
    bus_if.id_r2_enable_i  = 1'b0;
    bus_if.id_r1_addr_i    = 5'd0;
    bus_if.id_r2_addr_i    = 5'd0;
    bus_if.ex_is_load_i    = 1'b0;
    bus_if.ex_w_addr_i     = 5'd0;
    bus_if.mem_busy_i      = 1'b0;
    bus_if.branch_taken_i  = 1'b0;
    bus_if.branch_target_i = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_r1(input logic [4:0] a);
    bus_if.ex_is_load_i   = 1'b1;
    bus_if.ex_w_addr_i    = a;
    bus_if.id_r1_enable_i = 1'b1;
    bus_if.id_r1_addr_i   = a;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle();
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", {27'd0, bus_if.stall_o}, 32'd0);
    chk("rst_flush", {31'd0, bus_if.flush_o}, 32'd0);
    chk("rst_redir", {31'd0, bus_if.pc_redirect_o}, 32'd0);
    chk("rst_target", bus_if.pc_target_o, 32'd0);
    chk("rst_cnt", bus_if.stall_cnt_o, 32'd0);
    chk("rst_tmo", {31'd0, bus_if.timeout_o}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Load-use on read port 1
    tick(); idle(); load_use_r1(5'd5);
    @(negedge clk);
    chk("lu_r1_stall", {27'd0, bus_if.stall_o}, 32'h03);
    chk("lu_r1_cnt0", bus_if.stall_cnt_o, 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("lu_r1_next", {27'd0, bus_if.stall_o}, 32'h00);
    chk("lu_r1_cnt1", bus_if.stall_cnt_o, 32'd1);

    // Load-use on read port 2
    tick(); idle();
    bus_if.ex_is_load_i = 1'b1; bus_if.ex_w_addr_i = 5'd7;
    bus_if.id_r2_enable_i = 1'b1; bus_if.id_r2_addr_i = 5'd7;
    @(negedge clk);
    chk("lu_r2_stall", {27'd0, bus_if.stall_o}, 32'h03);
    // Same addresses but read port disabled
    tick(); bus_if.id_r2_enable_i = 1'b0;
    @(negedge clk);
    chk("lu_r2_dis", {27'd0, bus_if.stall_o}, 32'h00);
    // Non-load producer
    tick(); idle(); load_use_r1(5'd9); bus_if.ex_is_load_i = 1'b0;
    @(negedge clk);
    chk("lu_noload", {27'd0, bus_if.stall_o}, 32'h00);
    // x0 destination never hazards
    tick(); idle(); load_use_r1(5'd0);
    @(negedge clk);
    chk("lu_x0", {27'd0, bus_if.stall_o}, 32'h00);
    chk("lu_cnt2", bus_if.stall_cnt_o, 32'd2);

    // Branch in RUN: flush/redirect the following cycle only
    tick(); idle();
    bus_if.branch_taken_i = 1'b1; bus_if.branch_target_i = 32'h0000_0100;
    @(negedge clk);
    chk("br_n_flush", {31'd0, bus_if.flush_o}, 32'd0);
    chk("br_n_redir", {31'd0, bus_if.pc_redirect_o}, 32'd0);
    chk("br_n_stall", {27'd0, bus_if.stall_o}, 32'h00);
    tick(); idle(); load_use_r1(5'd5);
    bus_if.branch_taken_i = 1'b1; bus_if.branch_target_i = 32'h0000_0200;
    @(negedge clk);
    chk("br_n1_flush", {31'd0, bus_if.flush_o}, 32'd1);
    chk("br_n1_redir", {31'd0, bus_if.pc_redirect_o}, 32'd1);
    chk("br_n1_target", bus_if.pc_target_o, 32'h100);
    chk("br_n1_lu_sup", {27'd0, bus_if.stall_o}, 32'h00);
    tick(); idle();
    @(negedge clk);
    chk("br_n2_flush", {31'd0, bus_if.flush_o}, 32'd0);
    chk("br_n2_redir", {31'd0, bus_if.pc_redirect_o}, 32'd0);
    chk("br_n2_target", bus_if.pc_target_o, 32'h100);
    chk("br_cnt", bus_if.stall_cnt_o, 32'd2);

    // Branch with memory busy for 3 cycles; second branch is ignored
    tick(); idle();
    bus_if.branch_taken_i = 1'b1; bus_if.branch_target_i = 32'h0000_0300;
    bus_if.mem_busy_i = 1'b1;
    @(negedge clk);
    chk("bb_c0_stall", {27'd0, bus_if.stall_o}, 32'h1F);
    chk("bb_c0_flush", {31'd0, bus_if.flush_o}, 32'd0);
    tick(); bus_if.branch_target_i = 32'h0000_0400;
    @(negedge clk);
    chk("bb_c1_stall", {27'd0, bus_if.stall_o}, 32'h1F);
    tick(); bus_if.branch_taken_i = 1'b0;
    @(negedge clk);
    chk("bb_c2_stall", {27'd0, bus_if.stall_o}, 32'h1F);
    chk("bb_c2_flush", {31'd0, bus_if.flush_o}, 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("bb_c3_stall", {27'd0, bus_if.stall_o}, 32'h00);
    chk("bb_c3_flush", {31'd0, bus_if.flush_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("bb_c4_flush", {31'd0, bus_if.flush_o}, 32'd1);
    chk("bb_c4_redir", {31'd0, bus_if.pc_redirect_o}, 32'd1);
    chk("bb_c4_target", bus_if.pc_target_o, 32'h300);
    tick();
    @(negedge clk);
    chk("bb_c5_flush", {31'd0, bus_if.flush_o}, 32'd0);
    chk("bb_cnt", bus_if.stall_cnt_o, 32'd5);

    // Reset mid-MEM_WAIT with a pending branch
    tick(); idle();
    bus_if.mem_busy_i = 1'b1; bus_if.branch_taken_i = 1'b1;
    bus_if.branch_target_i = 32'h0000_0500;
    tick(); bus_if.branch_taken_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_stall", {27'd0, bus_if.stall_o}, 32'h00);
    chk("mr_flush", {31'd0, bus_if.flush_o}, 32'd0);
    chk("mr_redir", {31'd0, bus_if.pc_redirect_o}, 32'd0);
    chk("mr_target", bus_if.pc_target_o, 32'd0);
    chk("mr_cnt", bus_if.stall_cnt_o, 32'd0);
    chk("mr_tmo", {31'd0, bus_if.timeout_o}, 32'd0);
    tick();
    rst_n = 1'b1; idle();
    @(negedge clk);
    chk("mr_run_stall", {27'd0, bus_if.stall_o}, 32'h00);
    chk("mr_run_flush", {31'd0, bus_if.flush_o}, 32'd0);
    tick(); load_use_r1(5'd3);
    @(negedge clk);
    chk("mr_run_lu", {27'd0, bus_if.stall_o}, 32'h03);
    chk("mr_no_pend", {31'd0, bus_if.flush_o}, 32'd0);

    // Clean counters before the timeout run
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;

    // Memory busy for 300 cycles
    for (int k = 0; k < 300; k++) begin
      tick(); bus_if.mem_busy_i = 1'b1;
      @(negedge clk);
      if (k == 0)   chk("to_first_stall", {27'd0, bus_if.stall_o}, 32'h1F);
      if (k == 254) chk("to_pre", {31'd0, bus_if.timeout_o}, 32'd0);
      if (k == 255) chk("to_hit", {31'd0, bus_if.timeout_o}, 32'd1);
      if (k == 299) chk("to_last_stall", {27'd0, bus_if.stall_o}, 32'h1F);
    end
    tick(); bus_if.mem_busy_i = 1'b0;
    @(negedge clk);
    chk("to_exit_stall", {27'd0, bus_if.stall_o}, 32'h00);
    chk("to_cnt", bus_if.stall_cnt_o, 32'd300);
    tick();
    @(negedge clk);
    chk("to_sticky", {31'd0, bus_if.timeout_o}, 32'd1);
    chk("to_run_flush", {31'd0, bus_if.flush_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, in, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, in, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports id_r1_enable_i / id_r2_enable_i, in, 1 each, ID read-port enables.
REQ-004 SHALL have ports id_r1_addr_i / id_r2_addr_i, in, 5 each, ID read-port register addresses.
REQ-005 SHALL have port ex_is_load_i, in, 1, the instruction in EX is a load.
REQ-006 SHALL have port ex_w_addr_i, in, 5, destination register of the instruction in EX.
REQ-007 SHALL have port mem_busy_i, in, 1, MEM stage needs another cycle.
REQ-008 SHALL have port branch_taken_i, in, 1, EX resolved a taken branch/jump this cycle.
REQ-009 SHALL have port branch_target_i, in, 32, redirect address.
REQ-010 SHALL have port stall_o, out, 5, hold bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
REQ-011 SHALL have port flush_o, out, 1, squash IF/ID and ID/EX contents.
REQ-012 SHALL have port pc_redirect_o, out, 1, load PC from pc_target_o.
REQ-013 SHALL have port pc_target_o, out, 32, registered redirect address.
REQ-014 SHALL have port stall_cnt_o, out, 32, count of cycles with stall_o[0]=1.
REQ-015 SHALL have port timeout_o, out, 1, sticky MEM-wait timeout flag.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, FLUSH.
REQ-017 SHALL use stall semantics: bit k=1 holds register k; bit k=1 with bit k+1=0 means register k+1 receives a bubble.
REQ-018 SHALL detect load-use: ex_is_load_i && ex_w_addr_i!=0 && ((id_r1_enable_i && id_r1_addr_i==ex_w_addr_i) || (id_r2_enable_i && id_r2_addr_i==ex_w_addr_i)).
REQ-019 SHALL, in RUN with load-use and no other event, drive stall_o=5'b00011 combinationally in the same cycle; this is one bubble and FSM stays RUN.
REQ-020 SHALL, in RUN or FLUSH with mem_busy_i=1, drive stall_o=5'b11111 combinationally and go to MEM_WAIT.
REQ-021 SHALL hold stall_o=5'b11111 in MEM_WAIT while mem_busy_i=1, and return to RUN (or FLUSH if a branch is pending) in the cycle after mem_busy_i=0.
REQ-022 SHALL count MEM_WAIT cycles with an 8-bit counter cleared on MEM_WAIT entry; on reaching 255, it SHALL set timeout_o (sticky until reset) and keep waiting.
REQ-023 SHALL, on branch_taken_i=1 in RUN without mem_busy_i, latch branch_target_i into pc_target_o and enter FLUSH at the next edge.
REQ-024 SHALL, in FLUSH, assert flush_o=1 and pc_redirect_o=1 for exactly one cycle, then return to RUN.
REQ-025 SHALL, on branch_taken_i=1 together with mem_busy_i=1, latch the target, set pending, and perform FLUSH after MEM_WAIT exits.
REQ-026 SHALL apply priority mem_busy_i > flush > load-use; load-use stall is suppressed while flush_o=1 because the consumer is squashed.
REQ-027 SHALL ignore a second branch_taken_i while a branch is pending or in FLUSH, keeping the first target.
REQ-028 SHALL drive stall_o=0, flush_o=0, pc_redirect_o=0 in RUN when there are no events.
REQ-029 SHALL increment stall_cnt_o each cycle stall_o[0]=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-030 SHALL, with rst_n=0 at any time including mid-MEM_WAIT or FLUSH, force RUN, stall_o=0, flush_o=0, pc_redirect_o=0, pc_target_o=0, stall_cnt_o=0, timeout_o=0, wait counter=0, and clear the pending flag.

Verification
REQ-031 SHALL cover load-use: ex_is_load_i=1, ex_w_addr_i=5, id_r1_enable_i=1, id_r1_addr_i=5 -> stall_o=5'b00011 same cycle, 0 next cycle, stall_cnt_o=1.
REQ-032 SHALL cover the x0 case: the same stimulus with addresses 0 -> stall_o=0.
REQ-033 SHALL cover branch: branch_taken_i=1, target 32'h0000_0100 at cycle N -> flush_o=1, pc_redirect_o=1, pc_target_o=32'h100 in cycle N+1 only.
REQ-034 SHALL cover branch with busy memory: branch plus mem_busy_i=1 for 3 cycles -> stall_o=5'b11111 for 3 cycles, then a one-cycle FLUSH with the original target.
REQ-035 SHALL cover timeout: mem_busy_i held for 300 cycles -> timeout_o=1 from the 255th MEM_WAIT cycle, stall_cnt_o=300.
REQ-036 SHALL cover reset: rst_n pulsed low mid-MEM_WAIT -> all outputs 0 immediately, FSM in RUN after release.
